// File: rtl/ines_loader.sv
// iNES image loader: parses the 16-byte header, streams PRG/CHR bytes into the
// cartridge memories and holds the console in reset until loading completes.
module ines_loader #(
  parameter int unsigned PRG_ROM_DEPTH = 17,
  parameter int unsigned CHR_ROM_DEPTH = 13,
  parameter int unsigned SKIP_TRAINER  = 1
) (
  input  logic                     clk_cpu,
  input  logic                     rst,
  input  logic [7:0]               s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic                     prg_we,
  output logic [PRG_ROM_DEPTH-1:0] prg_addr,
  output logic                     chr_we,
  output logic [CHR_ROM_DEPTH-1:0] chr_addr,
  output logic [7:0]               wr_data,
  output logic [7:0]               mapper,
  output logic                     mirroring,
  output logic [7:0]               prg_banks,
  output logic [7:0]               chr_banks,
  output logic                     chr_is_ram,
  output logic                     sys_rst,
  output logic                     done,
  output logic                     err
);

  localparam int unsigned CNT_W = ((PRG_ROM_DEPTH > CHR_ROM_DEPTH) ? PRG_ROM_DEPTH : CHR_ROM_DEPTH) + 1;
  // Largest bank count that still fits the memory; saturates once any 8-bit value fits.
  localparam int unsigned PRG_MAX_BANKS = (PRG_ROM_DEPTH >= 22) ? 255 : (1 << (PRG_ROM_DEPTH - 14));
  localparam int unsigned CHR_MAX_BANKS = (CHR_ROM_DEPTH >= 21) ? 255 : (1 << (CHR_ROM_DEPTH - 13));

  typedef enum logic [2:0] {
    ST_HDR,
    ST_TRAINER,
    ST_PRG,
    ST_CHR,
    ST_DONE,
    ST_ERR
  } state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     trainer_q, trainer_d;
  logic                     s_ready_q, s_ready_d;
  logic                     prg_we_q, prg_we_d;
  logic                     chr_we_q, chr_we_d;
  logic [PRG_ROM_DEPTH-1:0] prg_addr_q, prg_addr_d;
  logic [CHR_ROM_DEPTH-1:0] chr_addr_q, chr_addr_d;
  logic [7:0]               wr_data_q, wr_data_d;
  logic [7:0]               mapper_q, mapper_d;
  logic                     mirroring_q, mirroring_d;
  logic [7:0]               prg_banks_q, prg_banks_d;
  logic [7:0]               chr_banks_q, chr_banks_d;
  logic                     chr_is_ram_q, chr_is_ram_d;
  logic                     sys_rst_q, sys_rst_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;

  logic accept_c;
  logic prg_last_c;
  logic chr_last_c;

  assign accept_c   = s_valid && s_ready_q;
  assign prg_last_c = (32'(cnt_q) + 32'd1) == (32'(prg_banks_q) << 14);
  assign chr_last_c = (32'(cnt_q) + 32'd1) == (32'(chr_banks_q) << 13);

  // State register and registered outputs.
  always_ff @(posedge clk_cpu) begin
    if (rst) begin
      state_q      <= ST_HDR;
      cnt_q        <= '0;
      trainer_q    <= 1'b0;
      s_ready_q    <= 1'b0;
      prg_we_q     <= 1'b0;
      chr_we_q     <= 1'b0;
      prg_addr_q   <= '0;
      chr_addr_q   <= '0;
      wr_data_q    <= '0;
      mapper_q     <= '0;
      mirroring_q  <= 1'b0;
      prg_banks_q  <= '0;
      chr_banks_q  <= '0;
      chr_is_ram_q <= 1'b0;
      sys_rst_q    <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      trainer_q    <= trainer_d;
      s_ready_q    <= s_ready_d;
      prg_we_q     <= prg_we_d;
      chr_we_q     <= chr_we_d;
      prg_addr_q   <= prg_addr_d;
      chr_addr_q   <= chr_addr_d;
      wr_data_q    <= wr_data_d;
      mapper_q     <= mapper_d;
      mirroring_q  <= mirroring_d;
      prg_banks_q  <= prg_banks_d;
      chr_banks_q  <= chr_banks_d;
      chr_is_ram_q <= chr_is_ram_d;
      sys_rst_q    <= sys_rst_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // Next-state, header decode and write generation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    trainer_d    = trainer_q;
    prg_we_d     = 1'b0;
    chr_we_d     = 1'b0;
    prg_addr_d   = prg_addr_q;
    chr_addr_d   = chr_addr_q;
    wr_data_d    = wr_data_q;
    mapper_d     = mapper_q;
    mirroring_d  = mirroring_q;
    prg_banks_d  = prg_banks_q;
    chr_banks_d  = chr_banks_q;
    chr_is_ram_d = chr_is_ram_q;
    // done lags DONE entry by one cycle so the final strobe lands first.
    done_d       = (state_q == ST_DONE);
    sys_rst_d    = (state_q != ST_DONE);

    if (accept_c) begin
      cnt_d = cnt_q + CNT_W'(1);
      case (state_q)
        ST_HDR: begin
          case (cnt_q[3:0])
            4'd0: if (s_data != 8'h4E) state_d = ST_ERR;
            4'd1: if (s_data != 8'h45) state_d = ST_ERR;
            4'd2: if (s_data != 8'h53) state_d = ST_ERR;
            4'd3: if (s_data != 8'h1A) state_d = ST_ERR;
            4'd4: begin
              prg_banks_d = s_data;
              if ((s_data == 8'h00) || (32'(s_data) > PRG_MAX_BANKS)) state_d = ST_ERR;
            end
            4'd5: begin
              chr_banks_d  = s_data;
              chr_is_ram_d = (s_data == 8'h00);
              if (32'(s_data) > CHR_MAX_BANKS) state_d = ST_ERR;
            end
            4'd6: begin
              mirroring_d    = s_data[0];
              trainer_d      = s_data[2];
              mapper_d[3:0]  = s_data[7:4];
              if (s_data[2] && (SKIP_TRAINER == 0)) state_d = ST_ERR;
            end
            4'd7:  mapper_d[7:4] = s_data[7:4];
            4'd15: state_d = trainer_q ? ST_TRAINER : ST_PRG;
            default: ;
          endcase
        end
        ST_TRAINER: begin
          if (cnt_q == CNT_W'(511)) state_d = ST_PRG;
        end
        ST_PRG: begin
          prg_we_d   = 1'b1;
          prg_addr_d = cnt_q[PRG_ROM_DEPTH-1:0];
          wr_data_d  = s_data;
          if (prg_last_c) state_d = (chr_banks_q != 8'h00) ? ST_CHR : ST_DONE;
        end
        ST_CHR: begin
          chr_we_d   = 1'b1;
          chr_addr_d = cnt_q[CHR_ROM_DEPTH-1:0];
          wr_data_d  = s_data;
          if (chr_last_c) state_d = ST_DONE;
        end
        default: ;
      endcase
    end

    if (state_d != state_q) cnt_d = '0;
    s_ready_d = (state_d == ST_HDR) || (state_d == ST_TRAINER) ||
                (state_d == ST_PRG) || (state_d == ST_CHR);
    err_d     = (state_d == ST_ERR);
  end

  assign s_ready    = s_ready_q;
  assign prg_we     = prg_we_q;
  assign chr_we     = chr_we_q;
  assign prg_addr   = prg_addr_q;
  assign chr_addr   = chr_addr_q;
  assign wr_data    = wr_data_q;
  assign mapper     = mapper_q;
  assign mirroring  = mirroring_q;
  assign prg_banks  = prg_banks_q;
  assign chr_banks  = chr_banks_q;
  assign chr_is_ram = chr_is_ram_q;
  assign sys_rst    = sys_rst_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_ines_loader.sv
// Bench for ines_loader: an image-position model predicts every output each cycle,
// plus directed literal checks for header decode, errors, trainer and mid-load reset.
module tb_ines_loader;

  localparam int unsigned PRG_W = 17;
  localparam int unsigned CHR_W = 13;

  logic             clk_cpu = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       s_data = 8'h00;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic             prg_we;
  logic [PRG_W-1:0] prg_addr;
  logic             chr_we;
  logic [CHR_W-1:0] chr_addr;
  logic [7:0]       wr_data;
  logic [7:0]       mapper;
  logic             mirroring;
  logic [7:0]       prg_banks;
  logic [7:0]       chr_banks;
  logic             chr_is_ram;
  logic             sys_rst;
  logic             done;
  logic             err;

  ines_loader #(.PRG_ROM_DEPTH(PRG_W), .CHR_ROM_DEPTH(CHR_W), .SKIP_TRAINER(1)) dut (
    .clk_cpu(clk_cpu), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .prg_we(prg_we), .prg_addr(prg_addr), .chr_we(chr_we), .chr_addr(chr_addr),
    .wr_data(wr_data), .mapper(mapper), .mirroring(mirroring), .prg_banks(prg_banks),
    .chr_banks(chr_banks), .chr_is_ram(chr_is_ram), .sys_rst(sys_rst), .done(done), .err(err)
  );

  always #5 clk_cpu = ~clk_cpu;

  int checks = 0;
  int failures = 0;
  int n_prg = 0;
  int n_chr = 0;
  bit abort = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model state: expected outputs derived from byte position within the image.
  logic             e_ready, e_prg_we, e_chr_we, e_mirroring, e_chr_is_ram;
  logic             e_sys_rst, e_done, e_err;
  logic [PRG_W-1:0] e_prg_addr;
  logic [CHR_W-1:0] e_chr_addr;
  logic [7:0]       e_wr_data, e_mapper, e_prg_banks, e_chr_banks;
  int               m_pos;
  bit               m_complete, m_trainer, m_started, m_acc;

  initial m_started = 1'b0;

  task automatic model_byte(input logic [7:0] b);
    int p, t, plen, clen, q;
    p = m_pos;
    m_pos++;
    if (p < 16) begin
      case (p)
        0: if (b != 8'h4E) e_err = 1'b1;
        1: if (b != 8'h45) e_err = 1'b1;
        2: if (b != 8'h53) e_err = 1'b1;
        3: if (b != 8'h1A) e_err = 1'b1;
        4: begin
          e_prg_banks = b;
          if (b == 8'h00 || int'(b) * 16384 > (1 << PRG_W)) e_err = 1'b1;
        end
        5: begin
          e_chr_banks  = b;
          e_chr_is_ram = (b == 8'h00);
          if (int'(b) * 8192 > (1 << CHR_W)) e_err = 1'b1;
        end
        6: begin
          e_mirroring   = b[0];
          m_trainer     = b[2];
          e_mapper[3:0] = b[7:4];
        end
        7: e_mapper[7:4] = b[7:4];
        default: ;
      endcase
    end else begin
      t    = m_trainer ? 512 : 0;
      plen = int'(e_prg_banks) * 16384;
      clen = int'(e_chr_banks) * 8192;
      q    = p - 16;
      if (q >= t) begin
        q -= t;
        if (q < plen) begin
          e_prg_we   = 1'b1;
          e_prg_addr = PRG_W'(q);
          e_wr_data  = b;
          if (q == plen - 1 && clen == 0) m_complete = 1'b1;
        end else begin
          q -= plen;
          e_chr_we   = 1'b1;
          e_chr_addr = CHR_W'(q);
          e_wr_data  = b;
          if (q == clen - 1) m_complete = 1'b1;
        end
      end
    end
  endtask

  always @(posedge clk_cpu) begin
    if (rst) begin
      e_ready = 0; e_prg_we = 0; e_chr_we = 0; e_prg_addr = '0; e_chr_addr = '0;
      e_wr_data = 0; e_mapper = 0; e_mirroring = 0; e_prg_banks = 0; e_chr_banks = 0;
      e_chr_is_ram = 0; e_sys_rst = 1; e_done = 0; e_err = 0;
      m_pos = 0; m_complete = 0; m_trainer = 0; m_acc = 0; m_started = 1;
    end else if (m_started) begin
      m_acc    = s_valid && e_ready;
      e_prg_we = 1'b0;
      e_chr_we = 1'b0;
      if (m_complete) begin
        e_done    = 1'b1;
        e_sys_rst = 1'b0;
      end
      if (m_acc) model_byte(s_data);
      e_ready = !m_complete && !e_err;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk_cpu) begin
    if (m_started) begin
      chk("s_ready", s_ready, e_ready);
      chk("prg_we", prg_we, e_prg_we);
      chk("chr_we", chr_we, e_chr_we);
      chk("prg_addr", prg_addr, e_prg_addr);
      chk("chr_addr", chr_addr, e_chr_addr);
      chk("wr_data", wr_data, e_wr_data);
      chk("mapper", mapper, e_mapper);
      chk("mirroring", mirroring, e_mirroring);
      chk("prg_banks", prg_banks, e_prg_banks);
      chk("chr_banks", chr_banks, e_chr_banks);
      chk("chr_is_ram", chr_is_ram, e_chr_is_ram);
      chk("sys_rst", sys_rst, e_sys_rst);
      chk("done", done, e_done);
      chk("err", err, e_err);
      chk("we_exclusive", prg_we & chr_we, 0);
      if (prg_we === 1'b1) n_prg++;
      if (chr_we === 1'b1) n_chr++;
    end
  end

  logic [7:0] hdr [16];

  task automatic set_hdr(input logic [7:0] b4, input logic [7:0] b5,
                         input logic [7:0] b6, input logic [7:0] b7);
    hdr[0] = 8'h4E; hdr[1] = 8'h45; hdr[2] = 8'h53; hdr[3] = 8'h1A;
    hdr[4] = b4; hdr[5] = b5; hdr[6] = b6; hdr[7] = b7;
    for (int i = 8; i < 16; i++) hdr[i] = 8'h00;
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 37 + (i >> 8));
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_cpu);
      #1;
    end
  endtask

  // Send image bytes [lo, hi), optionally with random s_valid gaps.
  task automatic send_range(input int lo, input int hi, input bit gaps);
    int waits;
    bit got;
    logic [7:0] b;
    for (int i = lo; i < hi && !abort; i++) begin
      b     = (i < 16) ? hdr[i] : pat(i);
      waits = 0;
      got   = 1'b0;
      while (!got) begin
        s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        s_data  = b;
        @(posedge clk_cpu);
        #1;
        got = m_acc;
        waits++;
        if (!got && waits > 200) begin
          checks++;
          failures++;
          $display("FAIL send_timeout actual=stalled byte %0d required=accepted", i);
          abort = 1'b1;
          got   = 1'b1;
        end
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    s_valid = 1'b0;
    idle(2);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_sys_rst", sys_rst, 1);
    chk("rst_prg_we", prg_we, 0);
    rst = 1'b0;
    idle(1);
    chk("post_rst_ready", s_ready, 1);
  endtask

  int n0, c0;

  initial begin
    do_reset();

    // Full-rate image: 2 PRG banks, 1 CHR bank.
    set_hdr(8'h02, 8'h01, 8'h00, 8'h00);
    n0 = n_prg;
    c0 = n_chr;
    send_range(0, 16 + 32768 + 8192, 1'b0);
    chk("last_chr_we", chr_we, 1);
    chk("last_chr_addr", chr_addr, 8191);
    chk("last_wr_data", wr_data, pat(16 + 32768 + 8191));
    chk("done_not_yet", done, 0);
    idle(1);
    chk("done_n2", done, 1);
    chk("sys_rst_n2", sys_rst, 0);
    chk("ready_done", s_ready, 0);
    chk("n_prg_full", n_prg - n0, 32768);
    chk("n_chr_full", n_chr - c0, 8192);
    chk("prg_banks_lit", prg_banks, 8'h02);
    chk("chr_banks_lit", chr_banks, 8'h01);

    // Bad magic byte 2.
    do_reset();
    set_hdr(8'h02, 8'h01, 8'h00, 8'h00);
    hdr[2] = 8'h54;
    n0 = n_prg;
    c0 = n_chr;
    send_range(0, 3, 1'b0);
    chk("magic_err", err, 1);
    chk("magic_ready", s_ready, 0);
    chk("magic_sys_rst", sys_rst, 1);
    idle(5);
    chk("magic_no_we", (n_prg - n0) + (n_chr - c0), 0);
    chk("magic_sys_rst_hold", sys_rst, 1);

    // 9 PRG banks exceed 128 KB.
    do_reset();
    set_hdr(8'h09, 8'h01, 8'h00, 8'h00);
    send_range(0, 5, 1'b0);
    chk("prg9_err", err, 1);
    chk("prg9_banks", prg_banks, 8'h09);

    // 8 PRG banks exactly fill the memory.
    do_reset();
    set_hdr(8'h08, 8'h01, 8'h00, 8'h00);
    send_range(0, 16, 1'b0);
    chk("prg8_no_err", err, 0);
    chk("prg8_ready", s_ready, 1);

    // Zero PRG banks.
    do_reset();
    set_hdr(8'h00, 8'h01, 8'h00, 8'h00);
    send_range(0, 5, 1'b0);
    chk("prg0_err", err, 1);

    // 2 CHR banks exceed 8 KB.
    do_reset();
    set_hdr(8'h01, 8'h02, 8'h00, 8'h00);
    send_range(0, 6, 1'b0);
    chk("chr2_err", err, 1);

    // Trainer image with backpressure, reset at PRG byte 1000, then restart.
    do_reset();
    set_hdr(8'h01, 8'h00, 8'h14, 8'h00);
    send_range(0, 16, 1'b1);
    idle(1);
    chk("tr_mapper", mapper, 8'h01);
    chk("tr_mirroring", mirroring, 0);
    chk("tr_chr_is_ram", chr_is_ram, 1);
    n0 = n_prg;
    send_range(16, 528, 1'b1);
    idle(1);
    chk("tr_no_we", n_prg - n0, 0);
    send_range(528, 528 + 1000, 1'b1);
    chk("tr_pre_rst_addr", prg_addr, 999);
    rst = 1'b1;
    idle(1);
    chk("midrst_prg_we", prg_we, 0);
    chk("midrst_mapper", mapper, 0);
    chk("midrst_sys_rst", sys_rst, 1);
    chk("midrst_prg_addr", prg_addr, 0);
    do_reset();
    n0 = n_prg;
    c0 = n_chr;
    send_range(0, 529, 1'b1);
    chk("restart_first_we", prg_we, 1);
    chk("restart_first_addr", prg_addr, 0);
    send_range(529, 16 + 512 + 16384, 1'b1);
    idle(2);
    chk("restart_n_prg", n_prg - n0, 16384);
    chk("restart_n_chr", n_chr - c0, 0);
    chk("restart_done", done, 1);
    chk("restart_sys_rst", sys_rst, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
